// File: rtl/tl_sensor_cond.sv
// tl_sensor_cond: synchronize, debounce and hold-stretch two car detectors into Ta/Tb plus arrival pulses
//   clk     - single clock, rising edge
//   reset   - synchronous active-high reset
//   tick    - time-base strobe; debounce and hold counters advance only when high
//   sa_raw  - raw asynchronous detector, street A
//   sb_raw  - raw asynchronous detector, street B
//   Ta, Tb  - conditioned traffic-present, registered
//   arr_a/b - one-cycle pulse on each new detection, registered
module tl_sensor_cond #(
    parameter int DB_CYCLES   = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int CW          = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sa_raw,
    input  logic sb_raw,
    output logic Ta,
    output logic Tb,
    output logic arr_a,
    output logic arr_b
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OCC  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0] raw;
    logic [1:0] t;
    logic [1:0] arr;

    assign raw   = {sb_raw, sa_raw};
    assign Ta    = t[0];
    assign Tb    = t[1];
    assign arr_a = arr[0];
    assign arr_b = arr[1];

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic          s1_q, s2_q, db_q, db_d, arr_q, arr_d;
        logic [CW-1:0] dcnt_q, dcnt_d, hcnt_q, hcnt_d;
        logic [1:0]    state_q, state_d;
        logic          dne, fire;

        always_ff @(posedge clk) begin
            if (reset) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                db_q    <= 1'b0;
                dcnt_q  <= '0;
                hcnt_q  <= '0;
                state_q <= IDLE;
                arr_q   <= 1'b0;
            end else begin
                s1_q    <= raw[c];
                s2_q    <= s1_q;
                db_q    <= db_d;
                dcnt_q  <= dcnt_d;
                hcnt_q  <= hcnt_d;
                state_q <= state_d;
                arr_q   <= arr_d;
            end
        end

        // debounced value flips only after DB_CYCLES consecutive disagreeing ticks
        always_comb begin
            dne    = s2_q != db_q;
            fire   = tick && dne && dcnt_q == CW'(DB_CYCLES - 1);
            db_d   = fire ? s2_q : db_q;
            dcnt_d = !tick ? dcnt_q : (!dne || fire) ? '0 : dcnt_q + CW'(1);
        end

        // re-detection in HOLD wins over hold expiry
        always_comb begin
            state_d = state_q;
            hcnt_d  = hcnt_q;
            if (state_q == IDLE && db_q) begin
                state_d = OCC;
            end else if (state_q == OCC && !db_q) begin
                state_d = HOLD;
                hcnt_d  = CW'(HOLD_CYCLES - 1);
            end else if (state_q == HOLD && db_q) begin
                state_d = OCC;
            end else if (state_q == HOLD && tick) begin
                state_d = (hcnt_q == '0) ? IDLE : HOLD;
                hcnt_d  = (hcnt_q == '0) ? hcnt_q : hcnt_q - CW'(1);
            end
        end

        always_comb begin
            arr_d = state_q == IDLE && db_q;
        end

        assign t[c]   = state_q != IDLE;
        assign arr[c] = arr_q;
    end
endmodule

// File: tb/tb_tl_sensor_cond.sv
// tb_tl_sensor_cond: randomized and scenario bench for tl_sensor_cond against a countdown-based reference model
module tb_tl_sensor_cond;
    localparam int DB   = 4;
    localparam int HOLD = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b1;
    logic sa_raw = 1'b0;
    logic sb_raw = 1'b0;
    logic Ta, Tb, arr_a, arr_b;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tl_sensor_cond #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .CW(4)) dut (
        .clk(clk), .reset(reset), .tick(tick), .sa_raw(sa_raw), .sb_raw(sb_raw),
        .Ta(Ta), .Tb(Tb), .arr_a(arr_a), .arr_b(arr_b)
    );

    // Reference model: sync pipe, run-length of disagreeing tick samples,
    // and a "ticks remaining before release" countdown for the hold stretch.
    bit m_s1[2], m_s2[2], m_db[2], m_T[2], m_occ[2], m_arr[2];
    int m_run[2], m_rem[2];
    bit [1:0] rw;

    always @(posedge clk) begin
        rw = {sb_raw, sa_raw};
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                m_s1[c] = 0; m_s2[c] = 0; m_db[c] = 0; m_T[c] = 0;
                m_occ[c] = 0; m_arr[c] = 0; m_run[c] = 0; m_rem[c] = 0;
            end else begin
                if (m_db[c]) begin
                    m_arr[c] = !m_T[c];
                    m_T[c] = 1; m_occ[c] = 1; m_rem[c] = HOLD;
                end else begin
                    m_arr[c] = 0;
                    if (m_T[c]) begin
                        if (m_occ[c]) m_occ[c] = 0;
                        else if (tick) begin
                            m_rem[c] = m_rem[c] - 1;
                            if (m_rem[c] == 0) m_T[c] = 0;
                        end
                    end
                end
                if (tick) begin
                    if (m_s2[c] != m_db[c]) begin
                        m_run[c] = m_run[c] + 1;
                        if (m_run[c] == DB) begin
                            m_db[c] = m_s2[c];
                            m_run[c] = 0;
                        end
                    end else m_run[c] = 0;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = rw[c];
            end
        end
    end

    task test_reset;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sa_raw = i[0];
            sb_raw = !i[0];
            @(negedge clk);
            checks++;
            if ({Ta, Tb, arr_a, arr_b} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b want=0000", i, {Ta, Tb, arr_a, arr_b});
            end
        end
        reset = 1'b0;
        sa_raw = 1'b0;
        sb_raw = 1'b0;
        @(negedge clk);
        checks++;
        if ({Ta, Tb, arr_a, arr_b} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_after got=%b want=0000", {Ta, Tb, arr_a, arr_b});
        end
        repeat (4) @(negedge clk);
    endtask

    task test_clean_arrival;
        sa_raw = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if ({Ta, arr_a, Tb, arr_b} !== {i >= 6, i == 6, 2'b00}) begin
                failures++;
                $display("FAIL arrival edge=E+%0d got Ta,arr_a,Tb,arr_b=%b want=%b", i, {Ta, arr_a, Tb, arr_b}, {i >= 6, i == 6, 2'b00});
            end
        end
    endtask

    task test_departure;
        sa_raw = 1'b0;
        for (int i = 0; i <= 17; i++) begin
            @(negedge clk);
            checks++;
            if ({Ta, arr_a} !== {i < 14, 1'b0}) begin
                failures++;
                $display("FAIL departure edge=F+%0d got Ta,arr_a=%b want=%b", i, {Ta, arr_a}, {i < 14, 1'b0});
            end
        end
    endtask

    task test_glitch;
        sb_raw = 1'b1;
        for (int i = 0; i <= 14; i++) begin
            @(negedge clk);
            if (i == 2) sb_raw = 1'b0;
            checks++;
            if ({Tb, arr_b} !== 2'b00) begin
                failures++;
                $display("FAIL glitch cyc=%0d got Tb,arr_b=%b want=00", i, {Tb, arr_b});
            end
        end
    endtask

    task test_rearrival;
        int pulses;
        sa_raw = 1'b1;
        repeat (10) @(negedge clk);
        sa_raw = 1'b0;
        pulses = 0;
        for (int i = 0; i <= 25; i++) begin
            @(negedge clk);
            if (i == 5) sa_raw = 1'b1;
            pulses += int'(arr_a);
            checks++;
            if (Ta !== 1'b1) begin
                failures++;
                $display("FAIL rearrival_T cyc=%0d got=%b want=1", i, Ta);
            end
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL rearrival_arr got=%0d pulses want=0", pulses);
        end
        test_departure();
    endtask

    task test_tick_gating;
        sa_raw = 1'b1;
        repeat (10) @(negedge clk);
        sa_raw = 1'b0;
        repeat (9) @(negedge clk);
        tick = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (Ta !== 1'b1) begin
                failures++;
                $display("FAIL gated_T cyc=%0d got=%b want=1", i, Ta);
            end
        end
        tick = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (Ta !== (i < 5)) begin
                failures++;
                $display("FAIL gated_expiry tick=%0d got=%b want=%b", i + 1, Ta, i < 5);
            end
        end
        sa_raw = 1'b1;
        repeat (10) @(negedge clk);
        sa_raw = 1'b0;
        repeat (9) @(negedge clk);
        tick = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick = 1'b1;
        checks++;
        if ({Ta, arr_a} !== 2'b00) begin
            failures++;
            $display("FAIL midhold_reset got Ta,arr_a=%b want=00", {Ta, arr_a});
        end
        sa_raw = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            checks++;
            if ({Ta, arr_a} !== {i >= 6, i == 6}) begin
                failures++;
                $display("FAIL post_reset_arrival edge=E+%0d got=%b want=%b", i, {Ta, arr_a}, {i >= 6, i == 6});
            end
        end
    endtask

    task test_random;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0) sa_raw = !sa_raw;
            if ($urandom_range(6) == 0) sb_raw = !sb_raw;
            tick = $urandom_range(9) < 7;
            reset = $urandom_range(399) == 0;
            @(negedge clk);
            checks++;
            if ({Ta, Tb, arr_a, arr_b} !== {m_T[0], m_T[1], m_arr[0], m_arr[1]}) begin
                failures++;
                $display("FAIL random cyc=%0d got Ta,Tb,arr_a,arr_b=%b want=%b", i, {Ta, Tb, arr_a, arr_b}, {m_T[0], m_T[1], m_arr[0], m_arr[1]});
            end
        end
        reset = 1'b0;
        tick = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_arrival();
        test_departure();
        test_glitch();
        test_rearrival();
        test_tick_gating();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
